// File: rtl/regdecr_pkg.sv
// Shared constants and helpers for the registered decrementer pipeline.
// Build option: define REGDECR_SATURATE_EN for saturate-at-zero stages.
package regdecr_pkg;

  localparam int unsigned REGDECR_NBITS_DEFAULT = 8;

  typedef struct packed {
    logic                             val;
    logic [REGDECR_NBITS_DEFAULT-1:0] data;
  } regdecr_stage_t;

  function automatic int unsigned regdecr_occ_width(input int unsigned nstages);
    return $clog2(nstages + 1);
  endfunction

endpackage

// File: rtl/regdecr_stage.sv
// One elastic val/rdy register stage that decrements the message by one.
// Build option: REGDECR_SATURATE_EN clamps the result at zero instead of wrapping.
module regdecr_stage
  import regdecr_pkg::*;
#(
  parameter int unsigned p_nbits = REGDECR_NBITS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_msg,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg
);

  logic               val_q, val_d;
  logic [p_nbits-1:0] data_q, data_d;
  logic [p_nbits-1:0] dec;

  always_comb begin
`ifdef REGDECR_SATURATE_EN
    dec = (in_msg == '0) ? '0 : in_msg - p_nbits'(1);
`else
    dec = in_msg - p_nbits'(1);
`endif
    // Empty, or the held message leaves this cycle: either way we can refill.
    in_rdy = !val_q || out_rdy;
    val_d  = val_q;
    data_d = data_q;
    if (in_rdy) val_d = in_val;
    if (in_rdy && in_val) data_d = dec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q  <= 1'b0;
      data_q <= '0;
    end else begin
      val_q  <= val_d;
      data_q <= data_d;
    end
  end

  assign out_val = val_q;
  assign out_msg = data_q;

endmodule

// File: rtl/regdecr_nstage_valrdy.sv
// N-stage elastic registered decrementer with val/rdy on both sides and an occupancy count.
// Build option: REGDECR_SATURATE_EN (passed through to every regdecr_stage).
module regdecr_nstage_valrdy
  import regdecr_pkg::*;
#(
  parameter int unsigned p_nbits   = REGDECR_NBITS_DEFAULT,
  parameter int unsigned p_nstages = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_val,
  output logic                                    in_rdy,
  input  logic [p_nbits-1:0]                      in_msg,
  output logic                                    out_val,
  input  logic                                    out_rdy,
  output logic [p_nbits-1:0]                      out_msg,
  output logic [regdecr_occ_width(p_nstages)-1:0] occupancy
);

  localparam int unsigned OW = regdecr_occ_width(p_nstages);

  for (genvar i = 0; i < p_nstages; i++) begin : g_stage
    logic               val;
    logic               rdy;
    logic               up_val;
    logic               down_rdy;
    logic [p_nbits-1:0] up_msg;
    logic [p_nbits-1:0] msg;

    if (i == 0) begin : g_head
      assign up_val = in_val;
      assign up_msg = in_msg;
    end else begin : g_body
      assign up_val = g_stage[i-1].val;
      assign up_msg = g_stage[i-1].msg;
    end

    // Ready ripples back combinationally from out_rdy; there are no skid buffers.
    if (i == p_nstages - 1) begin : g_tail
      assign down_rdy = out_rdy;
    end else begin : g_link
      assign down_rdy = g_stage[i+1].rdy;
    end

    regdecr_stage #(
      .p_nbits (p_nbits)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .in_val  (up_val),
      .in_rdy  (rdy),
      .in_msg  (up_msg),
      .out_val (val),
      .out_rdy (down_rdy),
      .out_msg (msg)
    );
  end

  assign in_rdy  = g_stage[0].rdy;
  assign out_val = g_stage[p_nstages-1].val;
  assign out_msg = g_stage[p_nstages-1].msg;

  logic          in_xfer;
  logic          out_xfer;
  logic [OW-1:0] occupancy_q, occupancy_d;

  always_comb begin
    in_xfer     = in_val && in_rdy;
    out_xfer    = out_val && out_rdy;
    occupancy_d = occupancy_q;
    if (in_xfer && !out_xfer)      occupancy_d = occupancy_q + OW'(1);
    else if (out_xfer && !in_xfer) occupancy_d = occupancy_q - OW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) occupancy_q <= '0;
    else       occupancy_q <= occupancy_d;
  end

  assign occupancy = occupancy_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (32'(occupancy_q) <= p_nstages);
      assert (!(out_xfer && !in_xfer && occupancy_q == '0));
      assert (!(in_xfer && !out_xfer && 32'(occupancy_q) == p_nstages));
    end
  end

endmodule

// File: tb/tb_regdecr_nstage_valrdy.sv
// Self-checking bench for regdecr_nstage_valrdy (N=2, 8-bit); honours REGDECR_SATURATE_EN.
module tb_regdecr_nstage_valrdy;

  localparam int unsigned NB = 8;
  localparam int unsigned NS = 2;

`ifdef REGDECR_SATURATE_EN
  localparam logic [7:0] EXP_FROM_01 = 8'h00;
  localparam logic [7:0] EXP_FROM_00 = 8'h00;
`else
  localparam logic [7:0] EXP_FROM_01 = 8'hFF;
  localparam logic [7:0] EXP_FROM_00 = 8'hFE;
`endif

  logic          clk;
  logic          reset;
  logic          in_val;
  logic          in_rdy;
  logic [NB-1:0] in_msg;
  logic          out_val;
  logic          out_rdy;
  logic [NB-1:0] out_msg;
  logic [1:0]    occupancy;

  regdecr_nstage_valrdy #(
    .p_nbits   (NB),
    .p_nstages (NS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_msg    (in_msg),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_msg   (out_msg),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb[$];
  logic       s_out_val;
  logic [7:0] s_out_msg;
  logic [1:0] s_occ;
  logic       s_in_rdy;
  logic       hold_pending = 1'b0;
  logic [7:0] hold_msg     = '0;

  function automatic logic [7:0] dec1(input logic [7:0] x);
`ifdef REGDECR_SATURATE_EN
    return (x == 8'h00) ? 8'h00 : x - 8'h01;
`else
    return x - 8'h01;
`endif
  endfunction

  function automatic logic [7:0] model(input logic [7:0] x);
    logic [7:0] y;
    y = x;
    for (int unsigned k = 0; k < NS; k++) y = dec1(y);
    return y;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, sample at the falling edge, run scoreboard checks, then step past the edge.
  task automatic apply(input logic iv, input logic [7:0] im, input logic ordy);
    in_val  = iv;
    in_msg  = im;
    out_rdy = ordy;
    @(negedge clk);
    s_out_val = out_val;
    s_out_msg = out_msg;
    s_occ     = occupancy;
    s_in_rdy  = in_rdy;
    chk("occupancy_vs_model", 32'(s_occ), 32'(sb.size()));
    if (hold_pending) begin
      chk("stall_val_held", 32'(out_val), 32'd1);
      chk("stall_msg_held", 32'(out_msg), 32'(hold_msg));
    end
    hold_pending = out_val && !out_rdy;
    hold_msg     = out_msg;
    if (out_val && out_rdy) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %0h expected none at %0t", out_msg, $time);
      end else begin
        chk("out_msg_order", 32'(out_msg), 32'(sb.pop_front()));
      end
    end
    if (in_val && in_rdy) sb.push_back(model(in_msg));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] im;
    logic       ordy;
    logic       eval;
    logic [7:0] emsg;
    logic [1:0] eocc;
    logic       erdy;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'd1, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 2'd1, 1'b1};
    tbl[3]  = '{1'b1, 8'd10, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[4]  = '{1'b1, 8'd20, 1'b1, 1'b0, 8'h00, 2'd1, 1'b1};
    tbl[5]  = '{1'b1, 8'd30, 1'b1, 1'b1, 8'd8,  2'd2, 1'b1};
    tbl[6]  = '{1'b1, 8'd40, 1'b1, 1'b1, 8'd18, 2'd2, 1'b1};
    tbl[7]  = '{1'b1, 8'h01, 1'b1, 1'b1, 8'd28, 2'd2, 1'b1};
    tbl[8]  = '{1'b1, 8'h00, 1'b1, 1'b1, 8'd38, 2'd2, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, EXP_FROM_01, 2'd2, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, EXP_FROM_00, 2'd1, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};

    reset   = 1'b1;
    in_val  = 1'b0;
    in_msg  = '0;
    out_rdy = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_out_val", 32'(out_val), 32'd0);
    chk("reset_occupancy", 32'(occupancy), 32'd0);
    chk("reset_in_rdy", 32'(in_rdy), 32'd1);
    chk("reset_out_msg", 32'(out_msg), 32'd0);
    reset = 1'b0;

    // Latency, streaming and wrap/saturate vectors.
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].iv, tbl[i].im, tbl[i].ordy);
      chk($sformatf("vec%0d_out_val", i), 32'(s_out_val), 32'(tbl[i].eval));
      chk($sformatf("vec%0d_occ", i), 32'(s_occ), 32'(tbl[i].eocc));
      chk($sformatf("vec%0d_in_rdy", i), 32'(s_in_rdy), 32'(tbl[i].erdy));
      if (tbl[i].eval) chk($sformatf("vec%0d_out_msg", i), 32'(s_out_msg), 32'(tbl[i].emsg));
    end

    // Backpressure: two accepts fill the pipe, the third waits.
    apply(1'b1, 8'h21, 1'b0);
    chk("bp_rdy_first", 32'(s_in_rdy), 32'd1);
    apply(1'b1, 8'h22, 1'b0);
    chk("bp_rdy_second", 32'(s_in_rdy), 32'd1);
    apply(1'b1, 8'h23, 1'b0);
    chk("bp_rdy_full", 32'(s_in_rdy), 32'd0);
    chk("bp_occ_full", 32'(s_occ), 32'd2);
    chk("bp_out_msg", 32'(s_out_msg), 32'(model(8'h21)));
    apply(1'b1, 8'h23, 1'b0);
    chk("bp_rdy_still_full", 32'(s_in_rdy), 32'd0);
    apply(1'b1, 8'h23, 1'b1);
    chk("bp_passthrough_rdy", 32'(s_in_rdy), 32'd1);
    for (int i = 0; i < 4; i++) apply(1'b0, 8'h00, 1'b1);
    chk("bp_drain_empty", 32'(sb.size()), 32'd0);

    // Reset mid-stream with two messages in flight.
    apply(1'b1, 8'h50, 1'b0);
    apply(1'b1, 8'h60, 1'b0);
    chk("rst_pre_occ", 32'(occupancy), 32'd2);
    in_val = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_out_val", 32'(out_val), 32'd0);
    chk("rst_async_occ", 32'(occupancy), 32'd0);
    chk("rst_async_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_async_out_msg", 32'(out_msg), 32'd0);
    sb.delete();
    hold_pending = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 8'h00, 1'b1);
      chk("rst_no_stale", 32'(s_out_val), 32'd0);
    end

    // Random valid/ready traffic against the scoreboard.
    for (int i = 0; i < 1000; i++) begin
      apply(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) apply(1'b0, 8'h00, 1'b1);
    chk("rand_drain_empty", 32'(sb.size()), 32'd0);
    chk("rand_final_occ", 32'(occupancy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regdecr_nstage_valrdy.md
Name: regdecr_nstage_valrdy

Overview:
- N-stage registered decrementer with val/rdy handshakes on input and output.
- Complementary direction of the team's registered-incrementer pipeline: a message incremented by N there returns to its original value here.
- Each stage registers and decrements by one; pipeline is elastic (stalls under backpressure, no drops, no duplicates).
- Used as the counterpart datapath in the regincr tutorial test harnesses and as a reusable elastic pipeline example.

Parameters:
p_nbits, 8, message width in bits (>=1)
p_nstages, 2, number of registered decrement stages (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_val  input  1  upstream message valid
in_rdy  output  1  block can accept a message this cycle
in_msg  input  p_nbits  upstream message
out_val  output  1  output message valid
out_rdy  input  1  downstream can accept
out_msg  output  p_nbits  decremented message
occupancy  output  $clog2(p_nstages+1)  number of valid messages in flight

Behaviour:
- Reset: asserting reset immediately (asynchronously) clears all stage valid bits and the occupancy counter to 0.
  - Reset-state outputs: out_val=0, occupancy=0, in_rdy=1, stage data regs=0, out_msg=0.
  - In-flight messages are discarded; no handshake completes in the cycle reset is sampled high.
- Stage i: holds val_i and data_i.
  - Stage 0 loads in_msg-1; stage i (i>0) loads data_{i-1}-1.
  - Arithmetic is modulo 2^p_nbits (0 wraps to all-ones), unless the Optional Feature is enabled.
- Advance rule:
  - Last stage: go_last = out_val && out_rdy.
  - Stage i accepts new data when !val_i || stage i is being drained this cycle.
  - rdy_i = !val_i || go_{i+1}, where go_{i+1} means the next stage accepts from stage i.
  - in_rdy = rdy_0. This is a combinational path from out_rdy through all stages; it is intentional (no skid buffers).
- Transfers: a transfer into stage i occurs when the upstream valid is high and rdy_i=1.
  - val_i is set by an incoming transfer and cleared when drained without refill.
  - Simultaneous drain and refill keeps val_i=1 with new data.
- Outputs: out_val = val_{N-1}; out_msg = data_{N-1}.
- Latency and throughput:
  - Latency is exactly p_nstages cycles from an accepted input (in_val&&in_rdy at edge k) to out_val at edge k+p_nstages, when out_rdy is held 1.
  - Throughput is 1 msg/cycle when out_rdy is held 1.
- Stall: with out_rdy=0, messages compact forward; in_rdy falls only when all N stages are valid.
  - Full occupancy with out_rdy=1 still accepts a new input (pass-through).
- Ordering: strictly FIFO; total output count equals total accepted input count.
- occupancy: registered counter.
  - +1 on an input transfer only; -1 on an output transfer only; unchanged when both or neither occur.
  - Never exceeds p_nstages or goes below 0 (assert in simulation).
- in_msg is ignored when in_val=0. out_msg is don't-care when out_val=0, but must be stable while out_val=1 && out_rdy=0.

Optional Feature:
- Macro REGDECR_SATURATE_EN.
- Defined: each stage computes (x==0) ? 0 : x-1, so values saturate at zero. Example: input 1 with N=2 yields 0.
- Undefined: wrap-around modulo 2^p_nbits. Example: input 1 with N=2 yields 8'hFF.
- Handshake, latency and occupancy behaviour are identical in both builds.

Decomposition:
- Shared package regdecr_pkg holds:
  - Default width constant (8).
  - Occupancy-width helper function.
  - Typedef for a stage struct {val, data}.
- Natural sub-module: regdecr_stage, one val/rdy register stage with its decrement and saturate option.
- The top level instantiates p_nstages stages with a generate loop, chains rdy/val between them, and adds the occupancy counter.

Test Plan:
- Reset directed: reset pulse mid-stream with 2 messages in flight -> out_val=0 and occupancy=0 immediately; in_rdy=1; no stale message emerges afterward.
- Basic latency: N=2, out_rdy=1, single in_msg=8'h05 accepted at cycle 0 -> out_val=1 with out_msg=8'h03 at cycle 2 only.
- Streaming: inputs 10,20,30,40 back-to-back with out_rdy=1 -> outputs 8,18,28,38 on four consecutive cycles; occupancy steady at 2.
- Backpressure: out_rdy=0 while feeding 3 messages -> in_rdy falls after 2 accepts; occupancy=2; out_msg held stable. Releasing out_rdy drains in order.
- Wrap/saturate: in_msg=8'h01 and 8'h00 with N=2 -> 8'hFF and 8'hFE by default; 0 and 0 with REGDECR_SATURATE_EN.
- Random val/rdy: random in_val and out_rdy for 1000 cycles, checked against a reference queue model -> exact data, order, and occupancy match.
